vmips_run_ctrl: RTL

- Hardware run controller that sits directly upstream and downstream of vmips_top.
- Upstream: loads a program into instruction memory from a host word stream, holds the core in reset, then owns the PC register (PC <= sPC each cycle).
- Downstream: detects halt (fetched instruction == 0) or timeout, then reads the result word from each of the four vector-memory lanes (x,y,z,w) and emits them on a valid/ready stream.

---
 rtl/vmips_run_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/vmips_run_ctrl.sv
// vmips_run_ctrl: program loader, PC owner and result drainer wrapped
// around vmips_top. Loads instruction memory from a host word stream,
// runs the core until it fetches a zero word or the cycle budget is
// spent, then streams the four lane result words out on valid/ready.
module vmips_run_ctrl #(
    parameter int IMEM_DEPTH = 64,
    parameter int IA_W       = 6,
    parameter int DA_W       = 5,
    parameter int RES_BASE   = 4,
    parameter int MAX_CYCLES = 30
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [31:0]     ld_data,
    input  logic            ld_last,
    output logic            imem_we,
    output logic [IA_W-1:0] imem_addr,
    output logic [31:0]     imem_wdata,
    output logic            core_rst,
    output logic [31:0]     pc_out,
    input  logic [31:0]     spc_in,
    input  logic [31:0]     inst_in,
    output logic            dmem_re,
    output logic [1:0]      dmem_lane,
    output logic [DA_W-1:0] dmem_addr,
    input  logic [31:0]     dmem_rdata,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [31:0]     res_data,
    output logic [1:0]      res_lane,
    output logic            res_last,
    output logic            busy,
    output logic            done,
    output logic            timeout,
    output logic [15:0]     cycle_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Drain sub-phases: issue the read, capture the returned word, hold it
    // until the consumer takes it.
    localparam logic [1:0] P_ISSUE   = 2'd0;
    localparam logic [1:0] P_CAPTURE = 2'd1;
    localparam logic [1:0] P_HOLD    = 2'd2;

    localparam logic [IA_W-1:0] LAST_IDX  = IA_W'(IMEM_DEPTH - 1);
    localparam logic [15:0]     CYC_LIMIT = 16'(MAX_CYCLES - 1);

    logic [2:0]      state;
    logic [1:0]      phase;
    logic [1:0]      lane_k;
    logic [IA_W-1:0] word_idx;

    // Strobes are pure decodes of registered state so they never glitch on
    // a state change; imem_we follows ld_valid so the write lands on the
    // handshake cycle itself.
    assign ld_ready   = (state == S_LOAD);
    assign imem_we    = (state == S_LOAD) && ld_valid;
    assign imem_addr  = word_idx;
    assign imem_wdata = ld_data;
    assign core_rst   = (state != S_RUN);
    assign dmem_re    = (state == S_DRAIN) && (phase == P_ISSUE);
    assign dmem_lane  = lane_k;
    assign dmem_addr  = DA_W'(RES_BASE) + {{(DA_W-2){1'b0}}, lane_k};
    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign done       = (state == S_DONE);

    // Main controller: state, load index, PC, run statistics and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            phase       <= P_ISSUE;
            lane_k      <= 2'd0;
            word_idx    <= {IA_W{1'b0}};
            pc_out      <= 32'd0;
            cycle_count <= 16'd0;
            timeout     <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= 32'd0;
            res_lane    <= 2'd0;
            res_last    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_LOAD;
                        word_idx    <= {IA_W{1'b0}};
                        cycle_count <= 16'd0;
                        timeout     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (ld_valid) begin
                        word_idx <= word_idx + IA_W'(1);
                        // The final slot ends the load even without ld_last,
                        // so excess host words simply stall.
                        if (ld_last || (word_idx == LAST_IDX)) begin
                            state  <= S_RUN;
                            pc_out <= 32'd0;
                        end
                    end
                end
                S_RUN: begin
                    if (cycle_count != 16'hFFFF) begin
                        cycle_count <= cycle_count + 16'd1;
                    end
                    // Halt is checked first so it wins over the budget.
                    if (inst_in == 32'd0) begin
                        state  <= S_DRAIN;
                        phase  <= P_ISSUE;
                        lane_k <= 2'd0;
                    end else begin
                        pc_out <= spc_in;
                        if (cycle_count == CYC_LIMIT) begin
                            state   <= S_DRAIN;
                            phase   <= P_ISSUE;
                            lane_k  <= 2'd0;
                            timeout <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    case (phase)
                        P_ISSUE: begin
                            phase <= P_CAPTURE;
                        end
                        P_CAPTURE: begin
                            res_data  <= dmem_rdata;
                            res_valid <= 1'b1;
                            res_lane  <= lane_k;
                            res_last  <= (lane_k == 2'd3);
                            phase     <= P_HOLD;
                        end
                        P_HOLD: begin
                            if (res_ready) begin
                                res_valid <= 1'b0;
                                phase     <= P_ISSUE;
                                if (lane_k == 2'd3) begin
                                    state <= S_DONE;
                                end else begin
                                    lane_k <= lane_k + 2'd1;
                                end
                            end
                        end
                        default: begin
                            phase <= P_ISSUE;
                        end
                    endcase
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
